// File: rtl/serial_work_transmit.sv
// Purpose : serialize one work unit {data2, midstate} as 44 bytes of 8N1 UART, LSB byte/bit first,
//           followed by GAP_BITS idle-high bit times.
// Latency : start bit on TxD one cycle after the accepting edge; busy for (440+GAP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: send is only sampled while idle; requests during a frame are dropped, not queued.
// Ports   : clk, reset_in (sync, active-low), send/midstate/data2 (request + work),
//           TxD (registered line), busy (frame in flight), done (1-cycle completion pulse).
module serial_work_transmit #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int GAP_BITS  = 16
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         send,
  input  logic [255:0] midstate,
  input  logic [95:0]  data2,
  output logic         TxD,
  output logic         busy,
  output logic         done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // Gap counter is sized for at least one bit so GAP_BITS=0 still elaborates;
  // in that configuration the GAP state is never entered.
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [5:0] LAST_BYTE = 6'd43;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]     bit_idx, bit_idx_nxt;
  logic [5:0]     byte_idx, byte_idx_nxt;
  logic [GW-1:0]  gap_idx, gap_idx_nxt;
  logic [351:0]   shreg, shreg_nxt;
  logic           txd_nxt, busy_nxt, done_nxt;
  logic           bit_end;
  logic [2:0]     bit_inc;
  logic [7:0]     cur_byte;

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    gap_idx_nxt  = gap_idx;
    shreg_nxt    = shreg;
    txd_nxt      = TxD;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    bit_end      = (baud_cnt == BAUD_LAST);
    bit_inc      = bit_idx + 3'd1;
    // The byte on the wire is always the low byte; the register shifts once per stop bit.
    cur_byte     = shreg[7:0];

    // Free-running wrap while a frame is active keeps every bit exactly CLKS_PER_BIT long.
    if (state != IDLE) begin
      baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (send && !busy) begin
          shreg_nxt    = {data2, midstate};
          state_nxt    = START;
          txd_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = 3'd0;
          byte_idx_nxt = 6'd0;
          gap_idx_nxt  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          txd_nxt     = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            bit_idx_nxt = bit_inc;
            txd_nxt     = cur_byte[bit_inc];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          shreg_nxt    = {8'h00, shreg[351:8]};
          byte_idx_nxt = byte_idx + 6'd1;
          if (byte_idx == LAST_BYTE) begin
            txd_nxt = 1'b1;
            if (GAP_BITS == 0) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt   = GAP;
              gap_idx_nxt = '0;
            end
          end else begin
            state_nxt = START;
            txd_nxt   = 1'b0;
          end
        end
      end
      GAP: begin
        txd_nxt = 1'b1;
        if (bit_end) begin
          if (gap_idx == GAP_LAST) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            gap_idx_nxt = gap_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 6'd0;
      gap_idx  <= '0;
      shreg    <= '0;
      TxD      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      gap_idx  <= gap_idx_nxt;
      shreg    <= shreg_nxt;
      TxD      <= txd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_work_transmit.sv
// Purpose : directed bench for serial_work_transmit (16 clocks/bit, 2 gap bits) plus a
//           fast instance (2 clocks/bit, no gap) decoded by a bench-side UART receiver.
// Latency : frames are tracked cycle by cycle from the accepting edge.
// Backpressure: exercises ignored send while busy and back-to-back frames with send held.
module tb_serial_work_transmit;

  localparam int C      = 16;
  localparam int GAP    = 2;
  localparam int FRAME  = (440 + GAP) * C;
  localparam int FC     = 2;
  localparam int FFRAME = 440 * FC;

  logic         clk = 1'b0;
  logic         reset_in, send;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         TxD, busy, done;

  logic         f_send;
  logic [255:0] f_mid;
  logic [95:0]  f_d2;
  logic         f_txd, f_busy, f_done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_work_transmit #(.CLK_FREQ(16), .BAUD_RATE(1), .GAP_BITS(GAP)) dut (
    .clk(clk), .reset_in(reset_in), .send(send), .midstate(midstate), .data2(data2),
    .TxD(TxD), .busy(busy), .done(done)
  );

  serial_work_transmit #(.CLK_FREQ(2), .BAUD_RATE(1), .GAP_BITS(0)) dut_lb (
    .clk(clk), .reset_in(reset_in), .send(f_send), .midstate(f_mid), .data2(f_d2),
    .TxD(f_txd), .busy(f_busy), .done(f_done)
  );

  task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle i after the accept edge, for c clocks per bit.
  function automatic logic exp_line(input logic [351:0] w, input int i, input int c);
    int b, p;
    b = i / c;
    if (b >= 440) return 1'b1;
    p = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[9'((b / 10) * 8 + p - 1)];
  endfunction

  function automatic logic [351:0] rand352();
    logic [351:0] r;
    for (int k = 0; k < 11; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Starts at a negedge with the DUT idle (or in its done cycle), requests w and
  // follows the whole frame. hold keeps send high and presents nw right after accept.
  task automatic run_frame(input string tag, input logic [351:0] w, input bit poke,
                           input bit hold, input logic [351:0] nw, output logic [351:0] got);
    int bad, busy_n, done_n, b, p;
    bad = 0; busy_n = 0; done_n = 0; got = '0;
    {data2, midstate} = w;
    send = 1'b1;
    @(negedge clk);
    if (hold) {data2, midstate} = nw;
    else begin
      send = 1'b0;
      {data2, midstate} = ~w;
    end
    check({tag, "_start_low"}, TxD, 0);
    check({tag, "_busy_rise"}, busy, 1);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (TxD !== exp_line(w, i, C)) bad++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) done_n++;
      b = i / C;
      p = b % 10;
      if (i % C == C / 2 && b < 440 && p >= 1 && p <= 8) got[9'((b / 10) * 8 + p - 1)] = TxD;
      if (poke && i == 100) begin
        {data2, midstate} = '1;
        send = 1'b1;
      end
      if (poke && i == 101) send = 1'b0;
    end
    check({tag, "_line_errs"}, bad, 0);
    check({tag, "_word"}, got, w);
    check({tag, "_busy_len"}, busy_n, FRAME);
    check({tag, "_early_done"}, done_n, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    logic [351:0] got, w1, w2, w;
    int cnt, low;

    reset_in = 1'b0;
    send     = 1'b1;
    midstate = '1;
    data2    = '1;
    f_send   = 1'b0;
    f_mid    = '0;
    f_d2     = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_in = 1'b1;
    send     = 1'b0;
    @(negedge clk);
    check("rst_nolatch_busy", busy, 0);
    check("rst_nolatch_txd", TxD, 1);

    run_frame("basic", {96'h3C00_0000_0000_0000_0000_0000, 256'hA5}, 1'b0, 1'b0, '0, got);
    check("basic_byte0", got[7:0], 8'hA5);
    check("basic_byte43", got[351:344], 8'h3C);
    check("basic_mid_zero", got[343:8], 0);
    @(negedge clk);
    check("basic_done_width", done, 0);

    run_frame("ignored", '0, 1'b1, 1'b0, '0, got);
    @(negedge clk);
    check("ignored_done_once", done, 0);
    check("ignored_idle", busy, 0);

    w1 = rand352();
    w2 = rand352();
    run_frame("b2b_1", w1, 1'b0, 1'b1, w2, got);
    run_frame("b2b_2", w2, 1'b0, 1'b0, '0, got);

    {data2, midstate} = w1;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (1650) @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    reset_in = 1'b1;
    check("midrst_txd", TxD, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    cnt = 0;
    low = 0;
    repeat (200) begin
      @(negedge clk);
      if (done !== 1'b0) cnt++;
      if (TxD !== 1'b1) low++;
    end
    check("midrst_no_done", cnt, 0);
    check("midrst_line_idle", low, 0);
    run_frame("post_rst", w2, 1'b0, 1'b0, '0, got);

    for (int v = 0; v < 20; v++) begin
      w = rand352();
      {f_d2, f_mid} = w;
      f_send = 1'b1;
      @(negedge clk);
      f_send = 1'b0;
      {f_d2, f_mid} = ~w;
      got = '0;
      for (int i = 0; i < FFRAME; i++) begin
        int b, p;
        if (i > 0) @(negedge clk);
        b = i / FC;
        p = b % 10;
        if (i % FC == FC - 1 && p >= 1 && p <= 8) got[9'((b / 10) * 8 + p - 1)] = f_txd;
      end
      @(negedge clk);
      check("lb_word", got, w);
      check("lb_done_busy", {f_done, f_busy}, 2'b10);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
